// File: rtl/tactile_pkg.sv
// Shared types and default geometry/timing constants for the tactile matrix scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tactile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SW_SETTLE,
    RD_SETTLE,
    CONVERT,
    ADVANCE
  } scan_state_t;

  localparam int DEF_SW_WIRE_CNT   = 16;
  localparam int DEF_RD_WIRE_CNT   = 16;
  localparam int DEF_SW_SETTLE_CYC = 256;
  localparam int DEF_RD_SETTLE_CYC = 32;
  localparam int DEF_ADC_TIMEOUT   = 1024;

  // Largest of three counts; sizes the shared settle/timeout counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with an expired flag, shared by settle and ADC-timeout phases.
// Latency: load takes effect next cycle; expired is combinational from the count.
// Backpressure: none; the owner reloads it on every state entry.
//
// Ports:
//   clk_in, rst   clock, synchronous active-high reset
//   load          load count with load_val this cycle (priority over decrement)
//   load_val      value loaded; a phase of N cycles is loaded with N-1
//   count         current count (lets the owner spot the first cycle of a phase)
//   expired       count has reached zero; counter holds at zero, never wraps
module scan_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign count   = cnt;
  assign expired = (cnt == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Raster scanner for the tactile matrix: drives row/column mux selects, settles, requests one ADC conversion per taxel.
// Latency: first adc_req 1+SW_SETTLE_CYC+RD_SETTLE_CYC cycles after start; point_strobe 1 cycle after adc_done.
// Backpressure: waits for adc_done up to ADC_TIMEOUT cycles per taxel, then flags adc_err and moves on.
//
// Ports:
//   clk_in, rst            clock, synchronous active-high reset
//   start / continuous     begin a scan (idle only); continuous latched on accepted start
//   stop                   finish the current frame, then return to idle
//   adc_done / adc_req     conversion handshake (adc_req is a single-cycle pulse)
//   sw_mux_sel/rd_mux_sel  row / column selects, row-major with column fastest
//   point_strobe           taxel sample valid; selects still address that taxel
//   frame_done             one-cycle pulse after the last taxel of a frame
//   busy / adc_err         not idle / sticky timeout flag
module matrix_scan_ctrl
  import tactile_pkg::*;
#(
  parameter int SW_WIRE_CNT   = DEF_SW_WIRE_CNT,
  parameter int RD_WIRE_CNT   = DEF_RD_WIRE_CNT,
  parameter int SW_SETTLE_CYC = DEF_SW_SETTLE_CYC,
  parameter int RD_SETTLE_CYC = DEF_RD_SETTLE_CYC,
  parameter int ADC_TIMEOUT   = DEF_ADC_TIMEOUT
) (
  input  logic                           clk_in,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           stop,
  input  logic                           adc_done,
  output logic                           adc_req,
  output logic [$clog2(SW_WIRE_CNT)-1:0] sw_mux_sel,
  output logic [$clog2(RD_WIRE_CNT)-1:0] rd_mux_sel,
  output logic                           point_strobe,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           adc_err
);

  localparam int SW_W  = $clog2(SW_WIRE_CNT);
  localparam int RD_W  = $clog2(RD_WIRE_CNT);
  localparam int CNT_W = $clog2(max3(SW_SETTLE_CYC, RD_SETTLE_CYC, ADC_TIMEOUT)) + 1;

  localparam logic [SW_W-1:0]  SW_LAST = SW_W'(SW_WIRE_CNT - 1);
  localparam logic [RD_W-1:0]  RD_LAST = RD_W'(RD_WIRE_CNT - 1);
  // Phases of N cycles load N-1 so the phase ends on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(ADC_TIMEOUT - 1);

  scan_state_t      state, state_nxt;
  logic [SW_W-1:0]  sw_sel, sw_nxt;
  logic [RD_W-1:0]  rd_sel, rd_nxt;
  logic             cont_q, stop_pend, err_q, strobe_q, frame_q;
  logic             strobe_nxt, frame_nxt, err_set, start_acc;
  logic             tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_val, tmr_count;

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt  = state;
    sw_nxt     = sw_sel;
    rd_nxt     = rd_sel;
    strobe_nxt = 1'b0;
    frame_nxt  = 1'b0;
    err_set    = 1'b0;
    start_acc  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          sw_nxt    = '0;
          rd_nxt    = '0;
          state_nxt = SW_SETTLE;
        end
      end
      SW_SETTLE: if (tmr_expired) state_nxt = RD_SETTLE;
      RD_SETTLE: if (tmr_expired) state_nxt = CONVERT;
      CONVERT: begin
        // A done on the final timeout cycle still counts as in time.
        if (adc_done) begin
          strobe_nxt = 1'b1;
          state_nxt  = ADVANCE;
        end else if (tmr_expired) begin
          err_set   = 1'b1;
          state_nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        if (rd_sel != RD_LAST) begin
          rd_nxt    = rd_sel + 1'b1;
          state_nxt = RD_SETTLE;
        end else begin
          rd_nxt = '0;
          if (sw_sel != SW_LAST) begin
            sw_nxt    = sw_sel + 1'b1;
            state_nxt = SW_SETTLE;
          end else begin
            sw_nxt    = '0;
            frame_nxt = 1'b1;
            // A stop arriving in this very cycle also ends the run.
            state_nxt = (cont_q && !stop_pend && !stop) ? SW_SETTLE : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Every state change reloads the shared timer for the phase being entered.
    tmr_load = (state_nxt != state);
    case (state_nxt)
      SW_SETTLE: tmr_val = SW_LD;
      RD_SETTLE: tmr_val = RD_LD;
      CONVERT:   tmr_val = TO_LD;
      default:   tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      sw_sel    <= '0;
      rd_sel    <= '0;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
      strobe_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sw_sel   <= sw_nxt;
      rd_sel   <= rd_nxt;
      strobe_q <= strobe_nxt;
      frame_q  <= frame_nxt;
      if (start_acc) cont_q <= continuous;
      if (state_nxt == IDLE)              stop_pend <= 1'b0;
      else if (stop && state != IDLE)     stop_pend <= 1'b1;
      if (start_acc)    err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  // The counter sits at its load value only on the first CONVERT cycle.
  assign adc_req      = (state == CONVERT) && (tmr_count == TO_LD);
  assign sw_mux_sel   = sw_sel;
  assign rd_mux_sel   = rd_sel;
  assign point_strobe = strobe_q;
  assign frame_done   = frame_q;
  assign busy         = (state != IDLE);
  assign adc_err      = err_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
module tb_matrix_scan_ctrl;
  localparam int SW = 3, RD = 5, SWS = 2, RDS = 1, TO = 8;
  localparam int NPT = SW * RD;

  logic clk_in = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0, stop = 1'b0, adc_done = 1'b0;
  logic adc_req, point_strobe, frame_done, busy, adc_err;
  logic [1:0] sw_mux_sel;
  logic [2:0] rd_mux_sel;

  matrix_scan_ctrl #(
    .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SW_SETTLE_CYC(SWS),
    .RD_SETTLE_CYC(RDS), .ADC_TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .adc_done(adc_done), .adc_req(adc_req), .sw_mux_sel(sw_mux_sel), .rd_mux_sel(rd_mux_sel),
    .point_strobe(point_strobe), .frame_done(frame_done), .busy(busy), .adc_err(adc_err)
  );

  initial forever #5 clk_in = ~clk_in;

  int total = 0, bad = 0, cyc = 0, start_cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ADC model: answers each request after a delay (0 = same cycle), optionally never for one taxel
  int  resp_mode = -1, skip_sw = 0, skip_rd = 0, pend = 0, rdelay = 0;
  bit  skip_en = 0, noise_en = 0;
  int  delay_q[$];
  initial forever begin
    @(negedge clk_in);
    adc_done = 1'b0;
    if (rst) pend = 0;
    else if (adc_req) begin
      if (!(skip_en && int'(sw_mux_sel) == skip_sw && int'(rd_mux_sel) == skip_rd)) begin
        rdelay = (resp_mode < 0) ? int'($urandom_range(0, 3)) : resp_mode;
        delay_q.push_back(rdelay);
        if (rdelay == 0) adc_done = 1'b1; else pend = rdelay;
      end
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) adc_done = 1'b1;
    end else if (noise_en && $urandom_range(0, 3) == 0) adc_done = 1'b1;
  end

  // Event log
  int strobe_q[$], strobe_cyc_q[$], req_cyc_q[$], exp_q[$];
  int frame_cnt = 0, dup_cnt = 0, sel_bad = 0, err_rise_cyc = -1, skip_req_cyc = -1;
  bit prev_req = 0, prev_err = 0;
  initial forever begin
    @(negedge clk_in);
    if (!rst) begin
      if (point_strobe) begin
        strobe_q.push_back(int'(sw_mux_sel) * 100 + int'(rd_mux_sel));
        strobe_cyc_q.push_back(cyc);
      end
      if (adc_req) begin
        req_cyc_q.push_back(cyc);
        if (prev_req) dup_cnt++;
        if (skip_en && int'(sw_mux_sel) == skip_sw && int'(rd_mux_sel) == skip_rd) skip_req_cyc = cyc;
      end
      if (frame_done) frame_cnt++;
      if (int'(sw_mux_sel) > SW - 1 || int'(rd_mux_sel) > RD - 1) sel_bad++;
      if (adc_err && !prev_err) err_rise_cyc = cyc;
    end
    prev_req = adc_req;
    prev_err = adc_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: row-major raster, column fastest, skipped taxel produces no sample
  function automatic void build_exp(input int frames, input bit skip, input int ss, input int sr);
    exp_q.delete();
    for (int f = 0; f < frames; f++)
      for (int s = 0; s < SW; s++)
        for (int r = 0; r < RD; r++)
          if (!(skip && s == ss && r == sr)) exp_q.push_back(s * 100 + r);
  endfunction

  function automatic int first_diff();
    int n;
    n = (strobe_q.size() < exp_q.size()) ? strobe_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (strobe_q[i] != exp_q[i]) return i;
    if (strobe_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_logs();
    strobe_q.delete(); strobe_cyc_q.delete(); req_cyc_q.delete(); delay_q.delete();
    frame_cnt = 0; dup_cnt = 0; sel_bad = 0; err_rise_cyc = -1; skip_req_cyc = -1;
  endtask

  task automatic do_start(input bit cont);
    start = 1'b1; continuous = cont; start_cyc = cyc;
    @(negedge clk_in);
    start = 1'b0; continuous = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk_in); n++; end
    total++;
    if (busy) begin bad++; $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, want 0", name, busy, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    total++;
    if ({adc_req, point_strobe, frame_done, busy, adc_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {adc_req, point_strobe, frame_done, busy, adc_err});
    end
    total++;
    if ({sw_mux_sel, rd_mux_sel} !== 5'b0) begin
      bad++; $display("FAIL reset_sel: got sw=%0d rd=%0d want 0 0", sw_mux_sel, rd_mux_sel);
    end
    rst = 1'b0;
    @(negedge clk_in);
    clear_logs();
  endtask

  task automatic test_single_frame();
    int d, late;
    clear_logs(); resp_mode = -1;
    do_start(1'b0);
    wait_idle(2000, "single");
    build_exp(1, 1'b0, 0, 0);
    total++;
    if (req_cyc_q.size() == 0 || req_cyc_q[0] != start_cyc + 1 + SWS + RDS) begin
      bad++; $display("FAIL first_req_time: got %0d want %0d", (req_cyc_q.size() > 0) ? req_cyc_q[0] - start_cyc : -1, 1 + SWS + RDS);
    end
    d = first_diff(); total++;
    if (d != -1) begin bad++; $display("FAIL single_seq: diff at %0d, got %0d strobes want %0d", d, strobe_q.size(), exp_q.size()); end
    total++;
    if (frame_cnt != 1) begin bad++; $display("FAIL single_frame_done: got %0d want 1", frame_cnt); end
    total++;
    if (req_cyc_q.size() != NPT) begin bad++; $display("FAIL single_req_cnt: got %0d want %0d", req_cyc_q.size(), NPT); end
    late = 0;
    for (int i = 0; i < strobe_cyc_q.size() && i < req_cyc_q.size() && i < delay_q.size(); i++)
      if (strobe_cyc_q[i] != req_cyc_q[i] + delay_q[i] + 1) late++;
    total++;
    if (late != 0 || strobe_cyc_q.size() != delay_q.size()) begin
      bad++; $display("FAIL strobe_timing: got %0d misplaced of %0d, want 0 of %0d", late, strobe_cyc_q.size(), delay_q.size());
    end
    total++;
    if (dup_cnt != 0 || sel_bad != 0) begin bad++; $display("FAIL single_req_sel: got dup=%0d selbad=%0d want 0 0", dup_cnt, sel_bad); end
  endtask

  task automatic test_coincident();
    int late;
    clear_logs(); resp_mode = 0;
    do_start(1'b0);
    wait_idle(2000, "coinc");
    late = 0;
    for (int i = 0; i < strobe_cyc_q.size() && i < req_cyc_q.size(); i++)
      if (strobe_cyc_q[i] != req_cyc_q[i] + 1) late++;
    total++;
    if (late != 0 || strobe_q.size() != NPT) begin
      bad++; $display("FAIL coinc_strobe: got late=%0d strobes=%0d want 0 %0d", late, strobe_q.size(), NPT);
    end
    total++;
    if (dup_cnt != 0 || req_cyc_q.size() != NPT) begin
      bad++; $display("FAIL coinc_req: got dup=%0d reqs=%0d want 0 %0d", dup_cnt, req_cyc_q.size(), NPT);
    end
    resp_mode = -1;
  endtask

  task automatic test_continuous_stop();
    int n, d, held;
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;   // stop while idle must not be remembered
    repeat (2) @(negedge clk_in);
    clear_logs();
    start = 1'b1; continuous = 1'b1; stop = 1'b1;   // start wins, this stop is dropped
    @(negedge clk_in);
    start = 1'b0; continuous = 1'b0; stop = 1'b0;
    n = 0;
    while (strobe_q.size() < 2 * NPT + 4 && n < 4000) begin @(negedge clk_in); n++; end
    total++;
    if (strobe_q.size() < 2 * NPT + 4) begin bad++; $display("FAIL cont_progress: got %0d strobes want >= %0d", strobe_q.size(), 2 * NPT + 4); end
    stop = 1'b1; @(negedge clk_in); stop = 1'b0;
    wait_idle(2000, "cont");
    held = strobe_q.size();
    repeat (20) @(negedge clk_in);
    build_exp(3, 1'b0, 0, 0);
    d = first_diff(); total++;
    if (d != -1) begin bad++; $display("FAIL cont_seq: diff at %0d, got %0d strobes want %0d", d, strobe_q.size(), exp_q.size()); end
    total++;
    if (frame_cnt != 3) begin bad++; $display("FAIL cont_frames: got %0d want 3", frame_cnt); end
    total++;
    if (sel_bad != 0 || busy !== 1'b0 || strobe_q.size() != held) begin
      bad++; $display("FAIL cont_after_stop: got selbad=%0d busy=%0b extra=%0d want 0 0 0", sel_bad, busy, strobe_q.size() - held);
    end
  endtask

  task automatic test_timeout();
    int d;
    clear_logs(); skip_en = 1; skip_sw = 1; skip_rd = 2;
    do_start(1'b0);
    wait_idle(2000, "timeout");
    skip_en = 0;
    build_exp(1, 1'b1, 1, 2);
    d = first_diff(); total++;
    if (d != -1) begin bad++; $display("FAIL timeout_seq: diff at %0d, got %0d strobes want %0d", d, strobe_q.size(), exp_q.size()); end
    total++;
    if (skip_req_cyc < 0 || err_rise_cyc < 0 || err_rise_cyc - skip_req_cyc != TO) begin
      bad++; $display("FAIL timeout_err_time: got req=%0d err=%0d want delta %0d", skip_req_cyc, err_rise_cyc, TO);
    end
    total++;
    if (adc_err !== 1'b1 || frame_cnt != 1) begin bad++; $display("FAIL timeout_sticky: got err=%0b frames=%0d want 1 1", adc_err, frame_cnt); end
    clear_logs();
    do_start(1'b0);
    total++;
    if (adc_err !== 1'b0) begin bad++; $display("FAIL err_clear_on_start: got %0b want 0", adc_err); end
    wait_idle(2000, "rescan");
    build_exp(1, 1'b0, 0, 0);
    d = first_diff(); total++;
    if (d != -1 || adc_err !== 1'b0) begin bad++; $display("FAIL rescan: diff at %0d err=%0b want -1 0", d, adc_err); end
  endtask

  task automatic test_ignored();
    int n, d;
    clear_logs(); noise_en = 1;
    repeat (6) @(negedge clk_in);   // spurious adc_done while idle
    do_start(1'b0);
    n = 0;
    while (n < 3000) begin
      @(negedge clk_in);
      if (!busy) break;
      start = ($urandom_range(0, 7) == 0);
      continuous = start;
      n++;
    end
    start = 1'b0; continuous = 1'b0; noise_en = 0;
    total++;
    if (busy) begin bad++; $display("FAIL ignored_idle_timeout: busy=%0b want 0", busy); end
    repeat (10) @(negedge clk_in);
    build_exp(1, 1'b0, 0, 0);
    d = first_diff(); total++;
    if (d != -1) begin bad++; $display("FAIL ignored_seq: diff at %0d, got %0d strobes want %0d", d, strobe_q.size(), exp_q.size()); end
    total++;
    if (frame_cnt != 1 || req_cyc_q.size() != NPT || busy !== 1'b0) begin
      bad++; $display("FAIL ignored_counts: got frames=%0d reqs=%0d busy=%0b want 1 %0d 0", frame_cnt, req_cyc_q.size(), busy, NPT);
    end
  endtask

  task automatic test_reset_mid();
    int n, d;
    clear_logs(); resp_mode = 1;
    do_start(1'b0);
    n = 0;
    while (!(adc_req && sw_mux_sel == 2'd1 && rd_mux_sel == 3'd1) && n < 2000) begin @(negedge clk_in); n++; end
    total++;
    if (!adc_req) begin bad++; $display("FAIL mid_reach_convert: adc_req=%0b want 1", adc_req); end
    rst = 1'b1;
    @(negedge clk_in);
    total++;
    if ({adc_req, point_strobe, frame_done, busy, adc_err, sw_mux_sel, rd_mux_sel} !== 10'b0) begin
      bad++; $display("FAIL mid_reset_outputs: got %b want 0", {adc_req, point_strobe, frame_done, busy, adc_err, sw_mux_sel, rd_mux_sel});
    end
    rst = 1'b0;
    @(negedge clk_in);
    clear_logs(); resp_mode = -1;
    do_start(1'b0);
    wait_idle(2000, "mid_rescan");
    build_exp(1, 1'b0, 0, 0);
    d = first_diff(); total++;
    if (d != -1 || frame_cnt != 1) begin bad++; $display("FAIL mid_rescan: diff at %0d frames=%0d want -1 1", d, frame_cnt); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_single_frame();
    test_coincident();
    test_continuous_stop();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
